ro_deser: RTL and testbench
===========================

# ro_deser

Readout deserializer on the shared tri-state readout bus driven by the per-channel readout blocks. Runs on the global external clock, mirrors the gray-counter slot schedule with its own binary slot counter, and samples the bus once per clock. Tags each bit with its channel index and timestamp, then buffers the tagged samples in a small FIFO with a valid/ready output for the off-chip capture interface.

## Interface
- NCH, 16: number of readout channels; channel k owns the slots where the gray counter's bit k toggles.
- CW, 17: slot/timestamp counter width; must equal the gray counter width (NCH+1).
- DEPTH, 4: output FIFO entries (power of 2, ≥2).
- clk_ext  in  1  global external clock, same net that clocks the gray counter; all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- en  in  1  counter/sampling enable; tied to the same enable as the gray counter.
- bus_in  in  1  shared readout bus (tri-state mux output).
- out_valid  out  1  FIFO head holds a sample.
- out_ready  in  1  consumer accepts the head when out_valid & out_ready.
- out_ch  out  $clog2(NCH)  channel index of head sample.
- out_bit  out  1  sampled bus value of head sample.
- out_ts  out  CW  slot timestamp of head sample.
- overflow  out  1  sticky: a valid sample was dropped on a full FIFO.

## Operation
- Slot counter c (CW bits): on each edge with en=1, c <= c+1 (wraps 2^CW-1 -> 0); en=0 holds c and takes no sample.
- Slot decode on edge with en=1: n = c+1 (mod 2^CW); slot = count of trailing zeros of n. Slot valid iff n≠0 and slot < NCH; otherwise idle slot, nothing stored.
- Stage 1 (same edge): register s_v = slot valid, s_ch = slot, s_bit = bus_in (z/x sampled as 0), s_ts = n.
- Stage 2 (next edge): if s_v, push {s_ch, s_bit, s_ts} into the FIFO. If FIFO full and no pop this edge: drop the sample, set overflow (cleared only by reset).
- Push and pop on the same edge: both happen; when full this is not an overflow.
- Pop: out_valid & out_ready on an edge removes the head; the outputs show the next entry, or out_valid=0 if the FIFO is empty.
- Outputs are the registered FIFO head; while out_valid=0, out_ch/out_bit/out_ts hold their last value.
- Channel schedule for n=1..8: 0,1,0,2,0,1,0,3. Channel k gets one slot per 2^(k+1) clocks.

## Timing
- Reset values: c=0, stage-1 regs 0, FIFO empty, out_valid=0, out_ch=0, out_bit=0, out_ts=0, overflow=0.
- Reset asserted mid-operation: all state clears immediately and in-flight samples are lost. The first slot after reset release is n=1.
- Latency: bus sampled at edge k -> out_valid=1 after edge k+1 if the FIFO was empty (2 edges).
- Throughput: at most one sample per clock. The FIFO drains at one entry per clock with out_ready=1.
- en deasserted: stage 1 loads s_v=0 on that edge; the pending stage-2 push still completes.
- Wrap: n=2^(CW-1) (slot NCH) and n=0 are idle slots. No FIFO write occurs for either.

## Structure
- Shared header ro_defs.vh: NCH, CW, DEPTH defaults and the FIFO entry width (clog2(NCH)+1+CW).
- Top module ro_deser: slot counter, trailing-zero priority encoder, stage-1 regs.
- Sub-module ro_fifo: synchronous FIFO, DEPTH entries, with push/pop/full/empty, simultaneous push-pop when full, async active-high reset.

## Test plan
- Reset, then en=1, out_ready=1, bus_in alternating 1,0 per clock from edge 1 -> outputs (ch,bit,ts) = (0,1,1),(1,0,2),(0,1,3),(2,0,4),(0,1,5),(1,0,6),(0,1,7),(3,0,8); first out_valid after edge 2.
- out_ready=0 from reset, run 8 edges -> out_valid=1, 4 entries held (ts 1..4), overflow=1 after the 5th valid sample (ts 5) is dropped; then out_ready=1 -> ts 1,2,3,4 pop in order, and the first sample pushed afterward is ts 6 or later.
- FIFO full with out_ready=1 on the same edge as a push -> no overflow, count stays 4.
- Force c=2^CW-2 and run 3 edges -> ts 2^CW-1 gives ch 0; n=0 produces no entry; n=1 gives ch 0, ts 1. Also check n=2^(CW-1) produces no entry.
- en=0 for 5 edges mid-run -> c frozen, no new entries; on resume, ts continues from the frozen value +1.
- Assert reset with 3 entries queued -> out_valid=0, overflow=0, out_ts=0 immediately (asynchronous, before the next edge).

Source files
------------

// File: rtl/ro_deser_pkg.sv
// =============================================================================
// ro_deser_pkg : shared defaults and sizing helpers for the readout deserializer
// Rev 1.0
// =============================================================================
`default_nettype none

package ro_deser_pkg;

  localparam int NCH_DEF   = 16;
  localparam int CW_DEF    = 17;
  localparam int DEPTH_DEF = 4;

  function automatic int ch_width(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

  // FIFO entry layout is {channel, bit, timestamp}
  function automatic int entry_width(input int nch, input int cw);
    return ch_width(nch) + 1 + cw;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ro_deser_fifo.sv
// =============================================================================
// ro_deser_fifo : synchronous FIFO with registered head and sticky overflow
// Rev 1.0
// =============================================================================
`default_nettype none

module ro_deser_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_head,
  output logic             o_overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             ovf_q, ovf_d;

  logic full, empty, do_push, do_pop;

  assign full  = (cnt_q == (AW+1)'(DEPTH));
  assign empty = (cnt_q == '0);

  always_comb begin
    do_pop  = i_pop && !empty;
    // a pop on the same edge frees the slot, so a full FIFO still accepts
    do_push = i_push && (!full || do_pop);

    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q | (i_push && full && !do_pop);

    if (do_push) begin
      mem_d[wr_q] = i_din;
      wr_d        = wr_q + AW'(1);
    end
    if (do_pop) begin
      rd_d = rd_q + AW'(1);
    end

    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase

    // reading mem_d lets a push into an empty FIFO appear at the head at once
    valid_d = (cnt_d != '0);
    head_d  = head_q;
    if (cnt_d != '0) begin
      head_d = mem_d[rd_d];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      head_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      head_q  <= head_d;
      ovf_q   <= ovf_d;
    end
  end

  assign o_valid    = valid_q;
  assign o_head     = head_q;
  assign o_overflow = ovf_q;

endmodule

`default_nettype wire

// File: rtl/ro_deser.sv
// =============================================================================
// ro_deser : readout bus deserializer - slot counter, slot decode, stage-1
//            capture and tagged-sample output FIFO
// Rev 1.0
// =============================================================================
`default_nettype none

module ro_deser
  import ro_deser_pkg::*;
#(
  parameter int NCH   = NCH_DEF,
  parameter int CW    = CW_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                      clk_ext,
  input  logic                      reset,
  input  logic                      en,
  input  logic                      bus_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ch_width(NCH)-1:0]  out_ch,
  output logic                      out_bit,
  output logic [CW-1:0]             out_ts,
  output logic                      overflow
);

  localparam int CHW = ch_width(NCH);
  localparam int EW  = entry_width(NCH, CW);

  logic [CW-1:0]  c_q, c_d;
  logic           s_v_q, s_v_d;
  logic [CHW-1:0] s_ch_q, s_ch_d;
  logic           s_bit_q, s_bit_d;
  logic [CW-1:0]  s_ts_q, s_ts_d;

  logic [CW-1:0]  n;
  int             tz;
  logic           slot_valid;

  always_comb begin
    n = c_q + CW'(1);

    // trailing-zero count: lowest set bit wins; n==0 leaves tz=CW (idle)
    tz = CW;
    for (int i = CW - 1; i >= 0; i--) begin
      if (n[i]) begin
        tz = i;
      end
    end
    slot_valid = (n != '0) && (tz < NCH);

    c_d     = c_q;
    s_v_d   = 1'b0;
    s_ch_d  = s_ch_q;
    s_bit_d = s_bit_q;
    s_ts_d  = s_ts_q;

    if (en) begin
      c_d     = n;
      s_v_d   = slot_valid;
      s_ch_d  = CHW'(tz);
      // a floating or unknown bus reads as 0
      s_bit_d = (bus_in === 1'b1);
      s_ts_d  = n;
    end
  end

  always_ff @(posedge clk_ext or posedge reset) begin
    if (reset) begin
      c_q     <= '0;
      s_v_q   <= 1'b0;
      s_ch_q  <= '0;
      s_bit_q <= 1'b0;
      s_ts_q  <= '0;
    end else begin
      c_q     <= c_d;
      s_v_q   <= s_v_d;
      s_ch_q  <= s_ch_d;
      s_bit_q <= s_bit_d;
      s_ts_q  <= s_ts_d;
    end
  end

  logic [EW-1:0] fifo_head;
  logic          fifo_valid;

  ro_deser_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk_ext),
    .rst        (reset),
    .i_push     (s_v_q),
    .i_din      ({s_ch_q, s_bit_q, s_ts_q}),
    .i_pop      (fifo_valid && out_ready),
    .o_valid    (fifo_valid),
    .o_head     (fifo_head),
    .o_overflow (overflow)
  );

  assign out_valid                 = fifo_valid;
  assign {out_ch, out_bit, out_ts} = fifo_head;

endmodule

`default_nettype wire

// File: tb/tb_ro_deser.sv
// Directed bench for ro_deser with a queue scoreboard; uses a reduced
// configuration (NCH=4, CW=5) so the counter wrap is reachable in a few edges.
`default_nettype none

module tb_ro_deser;

  localparam int NCH   = 4;
  localparam int CW    = 5;
  localparam int DEPTH = 4;
  localparam int CHW   = $clog2(NCH);

  typedef struct packed {
    logic [CHW-1:0] ch;
    logic           b;
    logic [CW-1:0]  ts;
  } smp_t;

  logic           clk_ext   = 1'b0;
  logic           reset     = 1'b1;
  logic           en        = 1'b0;
  logic           bus_in    = 1'b0;
  logic           out_ready = 1'b0;
  logic           out_valid;
  logic [CHW-1:0] out_ch;
  logic           out_bit;
  logic [CW-1:0]  out_ts;
  logic           overflow;

  int n_cmp = 0;
  int n_mis = 0;

  smp_t          q[$];
  smp_t          pend;
  logic          pend_v;
  logic [CW-1:0] m_c;
  logic          m_ovf;
  smp_t          last;

  int t1_ch [8] = '{0, 1, 0, 2, 0, 1, 0, 3};

  always #5 clk_ext = ~clk_ext;

  ro_deser #(
    .NCH   (NCH),
    .CW    (CW),
    .DEPTH (DEPTH)
  ) dut (
    .clk_ext   (clk_ext),
    .reset     (reset),
    .en        (en),
    .bus_in    (bus_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ch    (out_ch),
    .out_bit   (out_bit),
    .out_ts    (out_ts),
    .overflow  (overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    pend_v = 1'b0;
    pend   = '0;
    m_c    = '0;
    m_ovf  = 1'b0;
    last   = '0;
  endtask

  task automatic check_outputs();
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    if (q.size() != 0) last = q[0];
    chk("out_ch", 32'(out_ch), 32'(last.ch));
    chk("out_bit", 32'(out_bit), 32'(last.b));
    chk("out_ts", 32'(out_ts), 32'(last.ts));
    chk("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  // one clock edge: drive bus, advance the reference model, compare outputs
  task automatic step(input logic b);
    logic          pop;
    logic [CW-1:0] n;
    int            tz;
    bus_in = b;
    pop    = (q.size() != 0) && out_ready;
    @(posedge clk_ext);
    if (pop) void'(q.pop_front());
    if (pend_v) begin
      if (q.size() < DEPTH) q.push_back(pend);
      else m_ovf = 1'b1;
    end
    pend_v = 1'b0;
    if (en) begin
      n  = m_c + CW'(1);
      tz = CW;
      for (int i = CW - 1; i >= 0; i--) if (n[i]) tz = i;
      pend_v  = (n != '0) && (tz < NCH);
      pend.ch = tz[CHW-1:0];
      pend.b  = b;
      pend.ts = n;
      m_c     = n;
    end
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk_ext);
    #1;
    model_reset();
    check_outputs();
    reset = 1'b0;
  endtask

  initial begin
    model_reset();

    // reset state
    do_reset();

    // alternating bus, consumer always ready
    en = 1'b1; out_ready = 1'b1;
    for (int j = 1; j <= 10; j++) begin
      step(j % 2 == 1);
      if (j == 1) chk("t1_first_invalid", 32'(out_valid), 32'd0);
      if (j >= 2 && j <= 9) begin
        chk("t1_ch", 32'(out_ch), 32'(t1_ch[j-2]));
        chk("t1_bit", 32'(out_bit), 32'((j - 2) % 2 == 0));
        chk("t1_ts", 32'(out_ts), 32'(j - 1));
      end
    end

    // consumer stalled from reset: fill, overflow, then drain in order
    en = 1'b0; out_ready = 1'b0;
    do_reset();
    en = 1'b1;
    for (int j = 1; j <= 8; j++) step(1'b1);
    chk("t2_overflow", 32'(overflow), 32'd1);
    chk("t2_head_ts", 32'(out_ts), 32'd1);
    out_ready = 1'b1;
    for (int j = 1; j <= 4; j++) begin
      step(1'b0);
      if (j <= 3) chk("t2_drain_ts", 32'(out_ts), 32'(j + 1));
      else chk("t2_after_drop", 32'(out_ts >= 6), 32'd1);
    end
    for (int j = 0; j < 4; j++) step(1'b1);

    // push and pop on the same edge while full
    en = 1'b0; out_ready = 1'b0;
    do_reset();
    en = 1'b1;
    for (int j = 1; j <= 5; j++) step(1'b0);
    out_ready = 1'b1; en = 1'b0;
    step(1'b0);
    chk("t3_no_overflow", 32'(overflow), 32'd0);
    chk("t3_head_ts", 32'(out_ts), 32'd2);
    out_ready = 1'b0;
    step(1'b0);
    chk("t3_still_no_overflow", 32'(overflow), 32'd0);
    out_ready = 1'b1;
    for (int j = 1; j <= 5; j++) begin
      step(1'b0);
      chk("t3_drain_valid", 32'(out_valid), 32'(j <= 3));
    end

    // counter wrap, including the two idle slots
    en = 1'b0;
    do_reset();
    en = 1'b1;
    for (int j = 1; j <= 34; j++) begin
      step(j % 3 == 0);
      if (j == 17) chk("t4_mid_idle", 32'(out_valid), 32'd0);
      if (j == 32) begin
        chk("t4_top_ts", 32'(out_ts), 32'd31);
        chk("t4_top_ch", 32'(out_ch), 32'd0);
      end
      if (j == 33) chk("t4_zero_idle", 32'(out_valid), 32'd0);
      if (j == 34) begin
        chk("t4_wrap_ts", 32'(out_ts), 32'd1);
        chk("t4_wrap_ch", 32'(out_ch), 32'd0);
      end
    end

    // enable held low mid-run
    en = 1'b0;
    do_reset();
    en = 1'b1;
    for (int j = 1; j <= 6; j++) step(1'b1);
    en = 1'b0;
    for (int j = 1; j <= 5; j++) step(1'b1);
    chk("t5_frozen_empty", 32'(out_valid), 32'd0);
    en = 1'b1;
    step(1'b0);
    step(1'b0);
    chk("t5_resume_valid", 32'(out_valid), 32'd1);
    chk("t5_resume_ts", 32'(out_ts), 32'd7);
    step(1'b1);

    // asynchronous reset with entries queued
    en = 1'b0;
    do_reset();
    en = 1'b1; out_ready = 1'b0;
    for (int j = 1; j <= 4; j++) step(1'b1);
    chk("t6_queued_valid", 32'(out_valid), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_async_valid", 32'(out_valid), 32'd0);
    chk("t6_async_ts", 32'(out_ts), 32'd0);
    chk("t6_async_ovf", 32'(overflow), 32'd0);
    model_reset();
    @(posedge clk_ext);
    #1;
    check_outputs();
    reset = 1'b0;
    out_ready = 1'b1;
    step(1'b1);
    step(1'b0);
    chk("t6_first_after_reset", 32'(out_ts), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

`default_nettype wire
